if_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the fetch PC, issues instruction-memory reads and

---
 rtl/if_fetch_unit.sv | 212 +++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and keeps at most one
// instruction-memory read in flight. Returned words are buffered in a
// 2-entry FIFO whose head feeds the IF/ID pipeline register. A taken
// branch or jump (redirect) flushes the FIFO and squashes any read still
// in flight. When the FIFO is empty the outputs present a NOP, never stale
// data.
module if_fetch_unit #(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  imem_req_o,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [PC_WIDTH-1:0]   current_pc_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  if_valid_o
);

  // IDLE : one-cycle settle after reset release
  // REQ  : request presented, waiting for the grant (a FIFO slot is free)
  // WAIT : read granted, waiting for the data beat
  // FULL : FIFO holds two words, no room for another read
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  state_t                state;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  kill;
  logic                  req_q;

  // Two-entry FIFO of {pc, instruction}
  logic [PC_WIDTH-1:0]   fifo_pc   [2];
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            count_next;

  logic                  head_valid;
  logic                  pop;
  logic                  resp;
  logic                  push;
  logic [PC_WIDTH-1:0]   push_pc;
  logic [PC_WIDTH-1:0]   redirect_target;

  // Only the word-aligned part of the redirect address is meaningful.
  logic unused_redirect_low;
  assign unused_redirect_low = &{1'b0, redirect_pc_i[1:0]};

  assign redirect_target = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};

  assign head_valid = (count != 2'd0);

  // The consumer takes the head on the same edge it is popped here.
  assign pop = !stall && head_valid;

  // A data beat is only meaningful while a read is outstanding; beats seen in
  // any other state (e.g. a read that straddled a reset) are ignored.
  assign resp = (state == S_WAIT) && imem_rvalid_i;
  assign push = resp && !kill && !redirect_i;

  // fetch_pc was advanced by 4 when the outstanding read was granted, and any
  // redirect since then has killed that read, so the pushed word's PC is
  // always fetch_pc - 4.
  assign push_pc = fetch_pc - PC_WIDTH'(4);

  // Occupancy after this edge, counting a same-cycle push and pop.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes the buffer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count_next;
    end
  end

  // FIFO storage writes.
  // NOTE: the storage array has no reset; an entry is only ever observed
  // while count marks it valid, so its power-up contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_data[wr_ptr] <= imem_rdata_i;
    end
  end

  // Fetch FSM: state, fetch PC, kill flag and the registered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      kill     <= 1'b0;
      req_q    <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      case (state)
        S_REQ: begin
          if (imem_gnt_i) begin
            // The read just granted belongs to the old path.
            state <= S_WAIT;
            kill  <= 1'b1;
            req_q <= 1'b0;
          end else begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            // The stale beat arrives right now and is simply not pushed.
            state <= S_REQ;
            kill  <= 1'b0;
            req_q <= 1'b1;
          end else begin
            // Still outstanding: drop it when it arrives.
            state <= S_WAIT;
            kill  <= 1'b1;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= S_REQ;
          kill  <= 1'b0;
          req_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt_i) begin
            state    <= S_WAIT;
            req_q    <= 1'b0;
            fetch_pc <= fetch_pc + PC_WIDTH'(4);
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            kill <= 1'b0;
            if (count_next < 2'd2) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_FULL;
              req_q <= 1'b0;
            end
          end
        end
        S_FULL: begin
          if (pop) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = fetch_pc;

  // Presented instruction comes straight from the FIFO head; a bubble when empty.
  assign if_valid_o    = head_valid;
  assign current_pc_o  = head_valid ? fifo_pc[rd_ptr]   : '0;
  assign instruction_o = head_valid ? fifo_data[rd_ptr] : NOP_INST;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a transaction-level model (queue of fetched words,
// one in-flight read, next fetch address) is stepped alongside the DUT and
// every output is compared on every cycle, with directed scenarios pinning
// literal values and a randomized phase covering stalls, redirects, grant
// back-pressure, variable read latency, stray data beats and resets.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst, stall, redirect, gnt, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, valid;
  logic [31:0] addr, cur_pc, inst;

  // Second DUT for the address-wrap scenario
  logic        rst2, gnt2, rvalid2, stall2, redirect2;
  logic [31:0] rdata2, redirect_pc2;
  logic        req2, valid2;
  logic [31:0] addr2, cur_pc2, inst2;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .current_pc_o(cur_pc), .instruction_o(inst), .if_valid_o(valid)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(stall2),
    .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .current_pc_o(cur_pc2), .instruction_o(inst2), .if_valid_o(valid2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  entry_t      q[$];
  bit          model_ok = 0;
  bit          started  = 0;
  bit          inflight = 0;
  bit          killed   = 0;
  logic [31:0] next_pc  = 32'h0;
  logic [31:0] inflight_pc;

  // A request is up whenever fetching has started, nothing is in flight and
  // the buffer still has room for the word it would return.
  function automatic bit exp_req();
    return started && !inflight && (q.size() < 2);
  endfunction

  task automatic model_edge();
    bit     rq;
    bit     pop_now;
    entry_t e;
    rq = exp_req();
    if (rst) begin
      q.delete();
      started  = 0;
      inflight = 0;
      killed   = 0;
      next_pc  = 32'h0;
      model_ok = 1;
    end else if (redirect) begin
      q.delete();
      if (inflight) begin
        if (rvalid) begin
          inflight = 0;
          killed   = 0;
        end else begin
          killed = 1;
        end
      end else if (rq && gnt) begin
        inflight = 1;
        killed   = 1;
      end
      next_pc = {redirect_pc[31:2], 2'b00};
      started = 1;
    end else begin
      pop_now = !stall && (q.size() > 0);
      if (pop_now) void'(q.pop_front());
      if (inflight && rvalid) begin
        if (!killed) begin
          e.pc   = inflight_pc;
          e.data = rdata;
          q.push_back(e);
        end
        inflight = 0;
        killed   = 0;
      end
      if (rq && gnt) begin
        inflight    = 1;
        inflight_pc = next_pc;
        next_pc     = next_pc + 32'd4;
      end
      started = 1;
    end
  endtask

  // ---------------- memory stub ----------------
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;
  int          spur_pct = 0;
  logic [31:0] mem_data;
  logic [31:0] data_q[$];
  bit          dut_req_s = 0;

  function automatic bit mem_will_rvalid();
    return mem_busy && (mem_cnt == 0);
  endfunction

  task automatic mem_edge();
    if (rst) begin
      mem_busy = 0;
    end else begin
      if (mem_busy && rvalid) mem_busy = 0;
      else if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (dut_req_s && gnt) begin
        mem_busy = 1;
        mem_cnt  = mem_lat - 1;
        mem_data = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      end
    end
  endtask

  // One clock: drive memory response, step DUT and model, compare at negedge.
  task automatic cycle();
    dut_req_s = (req === 1'b1);
    rvalid    = mem_will_rvalid();
    rdata     = mem_busy ? mem_data : $urandom;
    if (!mem_busy && spur_pct > 0 && ($urandom % 100) < spur_pct) rvalid = 1'b1;
    @(posedge clk);
    model_edge();
    mem_edge();
    @(negedge clk);
    if (model_ok) begin
      check("req",   {31'b0, req},   {31'b0, exp_req()});
      check("addr",  addr,           next_pc);
      check("valid", {31'b0, valid}, {31'b0, (q.size() > 0)});
      check("pc",    cur_pc,         (q.size() > 0) ? q[0].pc   : 32'h0);
      check("inst",  inst,           (q.size() > 0) ? q[0].data : NOP);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; gnt = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic cycle2();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0;
    rst2 = 1'b1; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0; stall2 = 1'b0;
    redirect2 = 1'b0; redirect_pc2 = '0;

    // ---- 1: reset ----
    cycle();
    cycle();
    check("rst_req",   {31'b0, req},   32'd0);
    check("rst_addr",  addr,           32'h0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_pc",    cur_pc,         32'h0);
    check("rst_inst",  inst,           NOP);
    rst = 1'b0;
    cycle();
    check("rel_req",  {31'b0, req}, 32'd1);
    check("rel_addr", addr,         32'h0);

    // ---- 2: stream A, B, C ----
    begin
      logic [31:0] seen_pc[$];
      logic [31:0] seen_in[$];
      data_q = '{32'hA, 32'hB, 32'hC};
      mem_lat = 1; gnt = 1'b1;
      for (int i = 0; i < 7; i++) begin
        cycle();
        if (valid === 1'b1) begin
          seen_pc.push_back(cur_pc);
          seen_in.push_back(inst);
        end
      end
      check("stream_count", seen_pc.size(), 32'd3);
      if (seen_pc.size() == 3) begin
        check("stream_pc0", seen_pc[0], 32'h0); check("stream_in0", seen_in[0], 32'hA);
        check("stream_pc1", seen_pc[1], 32'h4); check("stream_in1", seen_in[1], 32'hB);
        check("stream_pc2", seen_pc[2], 32'h8); check("stream_in2", seen_in[2], 32'hC);
      end
    end

    // ---- 3: stall fills the FIFO ----
    data_q.delete();
    do_reset();
    data_q = '{32'h11, 32'h22};
    stall = 1'b1; gnt = 1'b1; mem_lat = 1;
    for (int i = 0; i < 10; i++) cycle();
    check("stall_req",  {31'b0, req}, 32'd0);
    check("stall_pc",   cur_pc,       32'h0);
    check("stall_inst", inst,         32'h11);
    stall = 1'b0;
    cycle();
    check("unstall_pc",   cur_pc,       32'h4);
    check("unstall_inst", inst,         32'h22);
    check("unstall_req",  {31'b0, req}, 32'd1);
    check("unstall_addr", addr,         32'h8);

    // ---- 4: redirect while the read of 0x8 is outstanding ----
    data_q.delete();
    do_reset();
    gnt = 1'b1; mem_lat = 1;
    begin
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (req === 1'b1 && addr === 32'h8) found = 1;
        else cycle();
      end
      check("redir_reach_8", {31'b0, found}, 32'd1);
    end
    data_q = '{32'hDEAD};
    mem_lat = 2;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect = 1'b0;
    cycle();
    check("redir_req",   {31'b0, req},   32'd1);
    check("redir_addr",  addr,           32'h100);
    check("redir_valid", {31'b0, valid}, 32'd0);
    mem_lat = 1;
    begin
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        cycle();
        if (valid === 1'b1) found = 1;
      end
      check("redir_first_seen", {31'b0, found}, 32'd1);
      check("redir_first_pc",   cur_pc,         32'h100);
    end

    // ---- 5: redirect + stall + rvalid in the same cycle ----
    do_reset();
    stall = 1'b1; gnt = 1'b1; mem_lat = 2;
    begin
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        if (mem_will_rvalid() && q.size() > 0) found = 1;
        else cycle();
      end
      check("rsr_setup", {31'b0, found}, 32'd1);
    end
    redirect = 1'b1; redirect_pc = 32'h202;
    cycle();
    redirect = 1'b0;
    check("rsr_valid", {31'b0, valid}, 32'd0);
    check("rsr_inst",  inst,           NOP);
    check("rsr_req",   {31'b0, req},   32'd1);
    check("rsr_addr",  addr,           32'h200);
    stall = 1'b0;

    // ---- 6: address wrap on the second instance ----
    cycle2();
    cycle2();
    check("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    cycle2();
    for (int i = 0; i < 5; i++) begin
      check("wrap_hold_req",  {31'b0, req2}, 32'd1);
      check("wrap_hold_addr", addr2,         32'hFFFF_FFFC);
      cycle2();
    end
    gnt2 = 1'b1;
    cycle2();
    gnt2 = 1'b0;
    check("wrap_addr0", addr2, 32'h0);
    rvalid2 = 1'b1; rdata2 = 32'h55;
    cycle2();
    rvalid2 = 1'b0;
    check("wrap_pc",   cur_pc2,        32'hFFFF_FFFC);
    check("wrap_inst", inst2,          32'h55);
    check("wrap_req",  {31'b0, req2},  32'd1);
    check("wrap_next", addr2,          32'h0);
    gnt2 = 1'b1;
    cycle2();
    gnt2 = 1'b0;
    rvalid2 = 1'b1; rdata2 = 32'h66;
    cycle2();
    rvalid2 = 1'b0;
    check("wrap_pc2",   cur_pc2, 32'h0);
    check("wrap_inst2", inst2,   32'h66);

    // ---- randomized phase ----
    data_q.delete();
    do_reset();
    spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      rst         = (($urandom % 400) == 0);
      stall       = (($urandom % 100) < 30);
      redirect    = (($urandom % 100) < 5);
      redirect_pc = $urandom;
      gnt         = (($urandom % 100) < 60);
      mem_lat     = 1 + ($urandom % 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
